sdram_ctrl: RTL and testbench

SDRAM_CTRL -- requirements
Module: sdram_ctrl

---
 rtl/sdram_ctrl_if.sv | 29 ++
 rtl/sdram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sdram_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_ctrl_if.sv
// sdram_ctrl_if: request/grant handshake and status bundle between a user master and sdram_ctrl.
interface sdram_ctrl_if;
    logic        wr_req;
    logic        rd_req;
    logic [8:0]  sdwr_bytes;
    logic [8:0]  sdrd_bytes;
    logic [3:0]  init_state;
    logic [3:0]  work_state;
    logic [15:0] cnt_clk;
    logic        sys_r_wn;
    logic        wr_ack;
    logic        rd_ack;
    logic        sdwr_en;
    logic        sdrd_en;
    logic        init_done;
    logic        busy;

    modport master (
        output wr_req, rd_req, sdwr_bytes, sdrd_bytes,
        input  init_state, work_state, cnt_clk, sys_r_wn, wr_ack, rd_ack,
               sdwr_en, sdrd_en, init_done, busy
    );

    modport slave (
        input  wr_req, rd_req, sdwr_bytes, sdrd_bytes,
        output init_state, work_state, cnt_clk, sys_r_wn, wr_ack, rd_ack,
               sdwr_en, sdrd_en, init_done, busy
    );
endinterface

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: SDRAM power-up init sequencer plus read/write/refresh work-state controller.
// Auto-refresh is compiled in only when the macro SDRAM_AUTO_REFRESH_EN is defined.
module sdram_ctrl #(
    parameter int T_PWR      = 20000,
    parameter int T_RP       = 2,
    parameter int T_RFC      = 7,
    parameter int T_MRD      = 2,
    parameter int T_RCD      = 2,
    parameter int CL         = 3,
    parameter int T_DAL      = 4,
    parameter int REF_PERIOD = 780
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    sdram_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        I_NOP = 4'd0, I_PRECHARGE = 4'd1, I_TRP = 4'd2, I_AUTO_REFRESH1 = 4'd3,
        I_TRF1 = 4'd4, I_AUTO_REFRESH2 = 4'd5, I_TRF2 = 4'd6, I_MRS = 4'd7,
        I_TMRD = 4'd8, I_DONE = 4'd9
    } init_state_t;

    typedef enum logic [3:0] {
        W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3, W_CL = 4'd4,
        W_RD = 4'd5, W_WRITE = 4'd6, W_WD = 4'd7, W_TDAL = 4'd8, W_AR = 4'd9,
        W_TRFC = 4'd10
    } work_state_t;

    init_state_t r_init_state, w_init_next;
    work_state_t r_work_state, w_work_next;
    logic [15:0] r_cnt_clk;
    logic [9:0]  r_burst;
    logic        r_sys_r_wn, r_wr_ack, r_rd_ack, r_sdwr_en, r_sdrd_en;
    logic        r_init_done, r_busy, r_last_wr;
    logic        w_grant_wr, w_grant_rd, w_ref_pend;
    logic [15:0] w_burst16;

    assign w_burst16 = {6'd0, r_burst};

    // A timed state of duration dur has finished on its last counted cycle.
    function automatic logic f_expired(input logic [15:0] cnt, input logic [15:0] dur);
        return cnt == (dur - 16'd1);
    endfunction

    // Init sequence next-state
    always_comb begin
        w_init_next = r_init_state;
        case (r_init_state)
            I_NOP:           w_init_next = f_expired(r_cnt_clk, 16'(T_PWR)) ? I_PRECHARGE : I_NOP;
            I_PRECHARGE:     w_init_next = I_TRP;
            I_TRP:           w_init_next = f_expired(r_cnt_clk, 16'(T_RP)) ? I_AUTO_REFRESH1 : I_TRP;
            I_AUTO_REFRESH1: w_init_next = I_TRF1;
            I_TRF1:          w_init_next = f_expired(r_cnt_clk, 16'(T_RFC)) ? I_AUTO_REFRESH2 : I_TRF1;
            I_AUTO_REFRESH2: w_init_next = I_TRF2;
            I_TRF2:          w_init_next = f_expired(r_cnt_clk, 16'(T_RFC)) ? I_MRS : I_TRF2;
            I_MRS:           w_init_next = I_TMRD;
            I_TMRD:          w_init_next = f_expired(r_cnt_clk, 16'(T_MRD)) ? I_DONE : I_TMRD;
            I_DONE:          w_init_next = I_DONE;
            default:         w_init_next = I_NOP;
        endcase
    end

    // Work next-state and arbitration: refresh first, then the request type not served last
    always_comb begin
        w_work_next = r_work_state;
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        case (r_work_state)
            W_IDLE: begin
                if (!r_init_done) begin
                    w_work_next = W_IDLE;
                end else if (w_ref_pend) begin
                    w_work_next = W_AR;
                end else if (bus.wr_req && (!bus.rd_req || !r_last_wr)) begin
                    w_grant_wr  = 1'b1;
                    w_work_next = W_ACTIVE;
                end else if (bus.rd_req) begin
                    w_grant_rd  = 1'b1;
                    w_work_next = W_ACTIVE;
                end else begin
                    w_work_next = W_IDLE;
                end
            end
            W_ACTIVE: w_work_next = W_TRCD;
            W_TRCD:   w_work_next = f_expired(r_cnt_clk, 16'(T_RCD)) ?
                                    (r_sys_r_wn ? W_WRITE : W_READ) : W_TRCD;
            W_WRITE:  w_work_next = (r_burst == 10'd1) ? W_TDAL : W_WD;
            W_WD:     w_work_next = f_expired(r_cnt_clk, w_burst16 - 16'd1) ? W_TDAL : W_WD;
            W_TDAL:   w_work_next = f_expired(r_cnt_clk, 16'(T_DAL)) ? W_IDLE : W_TDAL;
            W_READ:   w_work_next = W_CL;
            W_CL:     w_work_next = f_expired(r_cnt_clk, 16'(CL)) ? W_RD : W_CL;
            W_RD:     w_work_next = f_expired(r_cnt_clk, w_burst16) ? W_IDLE : W_RD;
            W_AR:     w_work_next = W_TRFC;
            W_TRFC:   w_work_next = f_expired(r_cnt_clk, 16'(T_RFC)) ? W_IDLE : W_TRFC;
            default:  w_work_next = W_IDLE;
        endcase
    end

    // State registers and the saturating per-state cycle counter
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_init_state <= I_NOP;
            r_work_state <= W_IDLE;
            r_cnt_clk    <= 16'd0;
        end else begin
            r_init_state <= w_init_next;
            r_work_state <= w_work_next;
            if ((w_init_next != r_init_state) || (w_work_next != r_work_state)) begin
                r_cnt_clk <= 16'd0;
            end else if (r_cnt_clk != 16'hFFFF) begin
                r_cnt_clk <= r_cnt_clk + 16'd1;
            end else begin
                r_cnt_clk <= r_cnt_clk;
            end
        end
    end

    // Grant latches and status outputs, all decoded from the next state so they align with it
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_sys_r_wn  <= 1'b1;
            r_wr_ack    <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_sdwr_en   <= 1'b0;
            r_sdrd_en   <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b1;
            r_last_wr   <= 1'b0;
            r_burst     <= 10'd0;
        end else begin
            r_wr_ack    <= w_grant_wr;
            r_rd_ack    <= w_grant_rd;
            r_sdwr_en   <= (w_work_next == W_WRITE) || (w_work_next == W_WD);
            r_sdrd_en   <= (w_work_next == W_RD);
            r_init_done <= (w_init_next == I_DONE);
            r_busy      <= (w_init_next != I_DONE) || (w_work_next != W_IDLE);
            if (w_grant_wr) begin
                r_sys_r_wn <= 1'b1;
                r_last_wr  <= 1'b1;
                r_burst    <= {(bus.sdwr_bytes == 9'd0), bus.sdwr_bytes};
            end else if (w_grant_rd) begin
                r_sys_r_wn <= 1'b0;
                r_last_wr  <= 1'b0;
                r_burst    <= {(bus.sdrd_bytes == 9'd0), bus.sdrd_bytes};
            end else begin
                r_sys_r_wn <= r_sys_r_wn;
                r_last_wr  <= r_last_wr;
                r_burst    <= r_burst;
            end
        end
    end

`ifdef SDRAM_AUTO_REFRESH_EN
    logic [15:0] r_ref_cnt;
    logic        r_ref_pend;

    // Refresh interval timer; runs once init is done and the pending flag waits out any burst
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt  <= 16'd0;
            r_ref_pend <= 1'b0;
        end else if (!r_init_done) begin
            r_ref_cnt  <= 16'd0;
            r_ref_pend <= 1'b0;
        end else if (r_ref_cnt == 16'(REF_PERIOD - 1)) begin
            r_ref_cnt  <= 16'd0;
            r_ref_pend <= 1'b1;
        end else begin
            r_ref_cnt  <= r_ref_cnt + 16'd1;
            r_ref_pend <= r_ref_pend && (w_work_next != W_AR);
        end
    end

    assign w_ref_pend = r_ref_pend;
`else
    assign w_ref_pend = 1'b0 && (REF_PERIOD != 0);
`endif

    assign bus.init_state = r_init_state;
    assign bus.work_state = r_work_state;
    assign bus.cnt_clk    = r_cnt_clk;
    assign bus.sys_r_wn   = r_sys_r_wn;
    assign bus.wr_ack     = r_wr_ack;
    assign bus.rd_ack     = r_rd_ack;
    assign bus.sdwr_en    = r_sdwr_en;
    assign bus.sdrd_en    = r_sdrd_en;
    assign bus.init_done  = r_init_done;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: self-checking bench for sdram_ctrl with a timeline model built from state durations.
`timescale 1ns/1ps
module tb_sdram_ctrl;
    localparam int T_PWR = 20, T_RP = 2, T_RFC = 7, T_MRD = 2, T_RCD = 2, CL = 3, T_DAL = 4;
`ifdef SDRAM_AUTO_REFRESH_EN
    localparam int REF_PERIOD = 100;
`else
    localparam int REF_PERIOD = 780;
`endif

    localparam logic [3:0] I_NOP = 4'd0, I_PRECHARGE = 4'd1, I_TRP = 4'd2, I_AUTO_REFRESH1 = 4'd3,
                           I_TRF1 = 4'd4, I_AUTO_REFRESH2 = 4'd5, I_TRF2 = 4'd6, I_MRS = 4'd7,
                           I_TMRD = 4'd8, I_DONE = 4'd9;
    localparam logic [3:0] W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_WD = 4'd7, W_AR = 4'd9, W_TRFC = 4'd10;

    logic clk_100m = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   model_last_wr;

    sdram_ctrl_if bus ();

    sdram_ctrl #(
        .T_PWR(T_PWR), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
        .T_RCD(T_RCD), .CL(CL), .T_DAL(T_DAL), .REF_PERIOD(REF_PERIOD)
    ) dut (
        .clk_100m(clk_100m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_100m = ~clk_100m;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [3:0] st[9];
        int         dur[9];
        logic [3:0] exp_st[$];
        int         exp_cnt[$];
        logic [3:0] es;
        st  = '{I_NOP, I_PRECHARGE, I_TRP, I_AUTO_REFRESH1, I_TRF1, I_AUTO_REFRESH2, I_TRF2, I_MRS, I_TMRD};
        dur = '{T_PWR, 1, T_RP, 1, T_RFC, 1, T_RFC, 1, T_MRD};
        rst_n = 1'b0;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        repeat (3) @(negedge clk_100m);
        n_cmp++;
        if ({bus.init_state, bus.work_state, bus.cnt_clk, bus.sys_r_wn, bus.wr_ack, bus.rd_ack,
             bus.sdwr_en, bus.sdrd_en, bus.init_done, bus.busy} !==
            {I_NOP, W_IDLE, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got st=%h ws=%h cnt=%0d rwn=%b ack=%b%b en=%b%b done=%b busy=%b",
                     bus.init_state, bus.work_state, bus.cnt_clk, bus.sys_r_wn, bus.wr_ack, bus.rd_ack,
                     bus.sdwr_en, bus.sdrd_en, bus.init_done, bus.busy);
        end
        model_last_wr = 1'b0;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < dur[i]; j++) begin
                exp_st.push_back(st[i]);
                exp_cnt.push_back(j);
            end
        // requests raised during init must be ignored
        bus.sdwr_bytes = 9'd5;
        bus.sdrd_bytes = 9'd5;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k <= exp_st.size(); k++) begin
            if (k > 0) @(negedge clk_100m);
            es = (k < exp_st.size()) ? exp_st[k] : I_DONE;
            n_cmp++;
            if (bus.init_state !== es) begin
                n_fail++;
                $display("FAIL init_state k=%0d: got %0d want %0d", k, bus.init_state, es);
            end
            n_cmp++;
            if (bus.init_done !== (k == exp_st.size()) || bus.busy !== (k != exp_st.size())) begin
                n_fail++;
                $display("FAIL init_done k=%0d: got done=%b busy=%b", k, bus.init_done, bus.busy);
            end
            n_cmp++;
            if ({bus.work_state, bus.wr_ack, bus.rd_ack} !== {W_IDLE, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL init_ignore_req k=%0d: got ws=%0d ack=%b%b want idle, no ack",
                         k, bus.work_state, bus.wr_ack, bus.rd_ack);
            end
            if (k < exp_st.size()) begin
                n_cmp++;
                if (bus.cnt_clk !== 16'(exp_cnt[k])) begin
                    n_fail++;
                    $display("FAIL init_cnt_clk k=%0d: got %0d want %0d", k, bus.cnt_clk, exp_cnt[k]);
                end
            end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic test_write();
        logic [8:0] lens[4];
        int n, first_en, n_en, idle_at;
        bit acked;
        lens[0] = 9'd4;
        lens[1] = 9'd1;
        lens[2] = 9'($urandom_range(2, 40));
        lens[3] = 9'($urandom_range(41, 300));
        foreach (lens[li]) begin
            n = (lens[li] == 9'd0) ? 512 : int'(lens[li]);
            @(negedge clk_100m);
            bus.sdwr_bytes = lens[li];
            bus.wr_req = 1'b1;
            acked = 1'b0;
            for (int i = 0; i < 100 && !acked; i++) begin
                @(negedge clk_100m);
                acked = bus.wr_ack;
            end
            bus.wr_req = 1'b0;
            bus.sdwr_bytes = 9'($urandom);
            n_cmp++;
            if ({acked, bus.work_state, bus.sys_r_wn, bus.busy} !== {1'b1, W_ACTIVE, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL wr_grant n=%0d: got ack=%b ws=%0d rwn=%b busy=%b", n, acked,
                         bus.work_state, bus.sys_r_wn, bus.busy);
            end
            if (acked) model_last_wr = 1'b1;
            first_en = -1; n_en = 0; idle_at = -1;
            for (int off = 1; off < n + 40 && idle_at < 0; off++) begin
                @(negedge clk_100m);
                if (off == 1) begin
                    n_cmp++;
                    if (bus.wr_ack !== 1'b0) begin
                        n_fail++;
                        $display("FAIL wr_ack_pulse: got wr_ack=%b want 0 one cycle later", bus.wr_ack);
                    end
                end
                if (bus.sdwr_en === 1'b1) begin
                    if (first_en < 0) first_en = off;
                    n_en++;
                end
                if (bus.work_state === W_IDLE) idle_at = off;
            end
            n_cmp++;
            if (first_en != T_RCD + 1 || n_en != n) begin
                n_fail++;
                $display("FAIL wr_window n=%0d: got start=%0d len=%0d want start=%0d len=%0d",
                         n, first_en, n_en, T_RCD + 1, n);
            end
            n_cmp++;
            if (idle_at != T_RCD + 1 + n + T_DAL || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_idle n=%0d: got idle_at=%0d busy=%b want %0d busy=0",
                         n, idle_at, bus.busy, T_RCD + 1 + n + T_DAL);
            end
        end
    endtask

    task automatic test_read();
        logic [8:0] lens[4];
        int n, first_en, n_en, idle_at, n_wr_en;
        bit acked;
        lens[0] = 9'd0;
        lens[1] = 9'd1;
        lens[2] = 9'($urandom_range(2, 40));
        lens[3] = 9'($urandom_range(41, 511));
        foreach (lens[li]) begin
            n = (lens[li] == 9'd0) ? 512 : int'(lens[li]);
            @(negedge clk_100m);
            bus.sdrd_bytes = lens[li];
            bus.rd_req = 1'b1;
            acked = 1'b0;
            for (int i = 0; i < 100 && !acked; i++) begin
                @(negedge clk_100m);
                acked = bus.rd_ack;
            end
            bus.rd_req = 1'b0;
            bus.sdrd_bytes = 9'($urandom);
            n_cmp++;
            if ({acked, bus.work_state, bus.sys_r_wn, bus.wr_ack} !== {1'b1, W_ACTIVE, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rd_grant n=%0d: got ack=%b ws=%0d rwn=%b wr_ack=%b", n, acked,
                         bus.work_state, bus.sys_r_wn, bus.wr_ack);
            end
            if (acked) model_last_wr = 1'b0;
            first_en = -1; n_en = 0; idle_at = -1; n_wr_en = 0;
            for (int off = 1; off < n + 40 && idle_at < 0; off++) begin
                @(negedge clk_100m);
                if (off == 1) begin
                    n_cmp++;
                    if (bus.rd_ack !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rd_ack_pulse: got rd_ack=%b want 0 one cycle later", bus.rd_ack);
                    end
                end
                if (bus.sdrd_en === 1'b1) begin
                    if (first_en < 0) first_en = off;
                    n_en++;
                end
                if (bus.sdwr_en === 1'b1) n_wr_en++;
                if (bus.work_state === W_IDLE) idle_at = off;
            end
            n_cmp++;
            if (first_en != T_RCD + 2 + CL || n_en != n || n_wr_en != 0) begin
                n_fail++;
                $display("FAIL rd_window n=%0d: got start=%0d len=%0d wr_en=%0d want start=%0d len=%0d wr_en=0",
                         n, first_en, n_en, n_wr_en, T_RCD + 2 + CL, n);
            end
            n_cmp++;
            if (idle_at != T_RCD + 2 + CL + n) begin
                n_fail++;
                $display("FAIL rd_idle n=%0d: got idle_at=%0d want %0d", n, idle_at, T_RCD + 2 + CL + n);
            end
        end
    endtask

    task automatic test_arbitration();
        int  n_grant, guard, extra;
        bit  prev_ack, exp_wr, idle_seen;
        @(negedge clk_100m);
        bus.sdwr_bytes = 9'($urandom_range(1, 8));
        bus.sdrd_bytes = 9'($urandom_range(1, 8));
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        prev_ack = 1'b0; n_grant = 0; guard = 0;
        while (n_grant < 3 && guard < 400) begin
            @(negedge clk_100m);
            guard++;
            if (bus.wr_ack || bus.rd_ack) begin
                exp_wr = !model_last_wr;
                model_last_wr = exp_wr;
                n_grant++;
                n_cmp++;
                if ({bus.wr_ack, bus.rd_ack, bus.sys_r_wn} !== {exp_wr, !exp_wr, exp_wr}) begin
                    n_fail++;
                    $display("FAIL arb_grant #%0d: got wr_ack=%b rd_ack=%b rwn=%b want write=%b",
                             n_grant, bus.wr_ack, bus.rd_ack, bus.sys_r_wn, exp_wr);
                end
                n_cmp++;
                if (prev_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL arb_ack_width #%0d: got ack high two cycles want one", n_grant);
                end
                if (n_grant == 3) begin
                    bus.wr_req = 1'b0;
                    bus.rd_req = 1'b0;
                end
            end
            prev_ack = bus.wr_ack || bus.rd_ack;
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        n_cmp++;
        if (n_grant != 3) begin
            n_fail++;
            $display("FAIL arb_timeout: got %0d grants want 3", n_grant);
        end
        extra = 0; idle_seen = 1'b0;
        for (int i = 0; i < 100 && !idle_seen; i++) begin
            @(negedge clk_100m);
            if (bus.wr_ack || bus.rd_ack) extra++;
            idle_seen = (bus.work_state === W_IDLE);
        end
        n_cmp++;
        if (extra != 0 || !idle_seen) begin
            n_fail++;
            $display("FAIL arb_after: got extra_acks=%0d idle=%b want 0 and 1", extra, idle_seen);
        end
    endtask

`ifdef SDRAM_AUTO_REFRESH_EN
    task automatic test_refresh();
        bit acked, en_seen, idle_seen, trfc_seen;
        @(negedge clk_100m);
        bus.sdrd_bytes = 9'd0;
        bus.rd_req = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < 100 && !acked; i++) begin
            @(negedge clk_100m);
            acked = bus.rd_ack;
        end
        bus.rd_req = 1'b0;
        if (acked) model_last_wr = 1'b0;
        en_seen = 1'b0;
        for (int i = 0; i < 50 && !en_seen; i++) begin
            @(negedge clk_100m);
            en_seen = bus.sdrd_en;
        end
        // write request left pending while the long read runs past a timer expiry
        bus.sdwr_bytes = 9'd3;
        bus.wr_req = 1'b1;
        idle_seen = 1'b0;
        for (int i = 0; i < 600 && !idle_seen; i++) begin
            @(negedge clk_100m);
            idle_seen = (bus.work_state === W_IDLE);
        end
        @(negedge clk_100m);
        n_cmp++;
        if ({acked, en_seen, idle_seen, bus.work_state, bus.wr_ack} !== {1'b1, 1'b1, 1'b1, W_AR, 1'b0}) begin
            n_fail++;
            $display("FAIL ref_after_burst: got ack=%b en=%b idle=%b ws=%0d wr_ack=%b want ws=%0d",
                     acked, en_seen, idle_seen, bus.work_state, bus.wr_ack, W_AR);
        end
        acked = 1'b0; trfc_seen = 1'b0;
        for (int i = 0; i < 40 && !acked; i++) begin
            @(negedge clk_100m);
            if (bus.work_state === W_TRFC) trfc_seen = 1'b1;
            acked = bus.wr_ack;
        end
        bus.wr_req = 1'b0;
        if (acked) model_last_wr = 1'b1;
        n_cmp++;
        if ({trfc_seen, acked} !== 2'b11) begin
            n_fail++;
            $display("FAIL ref_then_write: got trfc=%b wr_ack=%b want 1 1", trfc_seen, acked);
        end
        idle_seen = 1'b0;
        for (int i = 0; i < 60 && !idle_seen; i++) begin
            @(negedge clk_100m);
            idle_seen = (bus.work_state === W_IDLE);
        end
    endtask
`endif

    task automatic test_reset_mid_burst();
        bit in_wd;
        @(negedge clk_100m);
        bus.sdwr_bytes = 9'd100;
        bus.wr_req = 1'b1;
        in_wd = 1'b0;
        for (int i = 0; i < 150 && !in_wd; i++) begin
            @(negedge clk_100m);
            if (bus.wr_ack) bus.wr_req = 1'b0;
            in_wd = (bus.work_state === W_WD);
        end
        bus.wr_req = 1'b0;
        repeat (5) @(negedge clk_100m);
        n_cmp++;
        if ({in_wd, bus.work_state, bus.sdwr_en} !== {1'b1, W_WD, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_burst_setup: got in_wd=%b ws=%0d sdwr_en=%b", in_wd, bus.work_state, bus.sdwr_en);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.init_state, bus.work_state, bus.cnt_clk, bus.sys_r_wn, bus.wr_ack, bus.rd_ack,
             bus.sdwr_en, bus.sdrd_en, bus.init_done, bus.busy} !==
            {I_NOP, W_IDLE, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got st=%h ws=%h cnt=%0d rwn=%b ack=%b%b en=%b%b done=%b busy=%b",
                     bus.init_state, bus.work_state, bus.cnt_clk, bus.sys_r_wn, bus.wr_ack, bus.rd_ack,
                     bus.sdwr_en, bus.sdrd_en, bus.init_done, bus.busy);
        end
        test_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.sdwr_bytes = 9'd0;
        bus.sdrd_bytes = 9'd0;
        model_last_wr = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_arbitration();
`ifdef SDRAM_AUTO_REFRESH_EN
        test_refresh();
`endif
        test_reset_mid_burst();
        test_arbitration();
        test_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
